// File: rtl/melody_sequencer.sv
// Steps an 8-note A-major table, driving the tone generator's divider,
// enable and per-note duration with a silent gap between notes.
module melody_sequencer #(
   parameter int TICK_DIV  = 50000,
   parameter int GAP_TICKS = 20,
   parameter int NUM_NOTES = 8
) (
   input  logic        osc_CLK,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        loop,
   output logic [15:0] half_period,
   output logic        tone_en,
   output logic [2:0]  note_idx,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   localparam int          PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
   localparam logic [9:0]  GAPD = 10'(GAP_TICKS);
   localparam logic [2:0]  LAST = 3'(NUM_NOTES - 1);

   state_t        r_state, w_state;
   logic [PW-1:0] r_pres, w_pres;
   logic [9:0]    r_dur, w_dur;
   logic [15:0]   r_hp, w_hp;
   logic [2:0]    r_idx, w_idx;
   logic          r_tone, w_tone;
   logic          r_busy, w_busy;
   logic          r_done, w_done;
   logic          w_tick, w_end;
   logic [2:0]    w_nidx;
   logic [15:0]   w_rom_hp;
   logic [9:0]    w_rom_dur;

   function automatic logic [25:0] note_rom(input logic [2:0] i);
      logic [25:0] v;
      case (i)
         3'd0:    v = {16'd56818, 10'd250};
         3'd1:    v = {16'd50607, 10'd250};
         3'd2:    v = {16'd45126, 10'd250};
         3'd3:    v = {16'd42589, 10'd250};
         3'd4:    v = {16'd37936, 10'd250};
         3'd5:    v = {16'd33783, 10'd250};
         3'd6:    v = {16'd30084, 10'd250};
         default: v = {16'd28409, 10'd500};
      endcase
      return v;
   endfunction

   // Index of the note loaded on the next PLAY entry (0 from IDLE or wrap).
   assign w_nidx = (r_state == GAP && r_idx != LAST) ? r_idx + 3'd1 : 3'd0;
   assign {w_rom_hp, w_rom_dur} = note_rom(w_nidx);

   assign w_tick = (r_state != IDLE) && (r_pres == PMAX);
   assign w_end  = w_tick && (r_dur == 10'd1);

   always_comb begin
      w_state = r_state;
      w_pres  = r_pres;
      w_dur   = r_dur;
      w_hp    = r_hp;
      w_idx   = r_idx;
      w_tone  = r_tone;
      w_busy  = r_busy;
      w_done  = 1'b0;
      if (r_state != IDLE) begin
         w_pres = w_tick ? '0 : r_pres + 1'b1;
         if (w_tick) w_dur = r_dur - 10'd1;
      end
      if (stop) begin
         w_state = IDLE;
         w_tone  = 1'b0;
         w_busy  = 1'b0;
         w_pres  = '0;
         w_dur   = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  w_state = PLAY;
                  w_idx   = w_nidx;
                  w_hp    = w_rom_hp;
                  w_dur   = w_rom_dur;
                  w_tone  = 1'b1;
                  w_busy  = 1'b1;
                  w_pres  = '0;
               end
            end
            PLAY: begin
               if (w_end) begin
                  w_state = GAP;
                  w_tone  = 1'b0;
                  w_dur   = GAPD;
                  w_pres  = '0;
               end
            end
            GAP: begin
               if (w_end) begin
                  if (r_idx != LAST || loop) begin
                     w_state = PLAY;
                     w_idx   = w_nidx;
                     w_hp    = w_rom_hp;
                     w_dur   = w_rom_dur;
                     w_tone  = 1'b1;
                     w_pres  = '0;
                  end else begin
                     w_state = IDLE;
                     w_busy  = 1'b0;
                     w_done  = 1'b1;
                     w_pres  = '0;
                     w_dur   = '0;
                  end
               end
            end
            default: w_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge osc_CLK or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_pres  <= '0;
         r_dur   <= '0;
         r_hp    <= '0;
         r_idx   <= '0;
         r_tone  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_pres  <= w_pres;
         r_dur   <= w_dur;
         r_hp    <= w_hp;
         r_idx   <= w_idx;
         r_tone  <= w_tone;
         r_busy  <= w_busy;
         r_done  <= w_done;
      end
   end

   assign half_period = r_hp;
   assign tone_en     = r_tone;
   assign note_idx    = r_idx;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=4, GAP_TICKS=2.
module tb_melody_sequencer;

   localparam int TD = 4;
   localparam int GT = 2;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        stop  = 1'b0;
   logic        loop  = 1'b0;
   logic [15:0] half_period;
   logic        tone_en;
   logic [2:0]  note_idx;
   logic        busy;
   logic        done;

   int n_run  = 0;
   int n_fail = 0;
   logic [15:0] tbl [8];

   melody_sequencer #(
      .TICK_DIV(TD),
      .GAP_TICKS(GT),
      .NUM_NOTES(8)
   ) dut (
      .osc_CLK(clk),
      .rst_n(rst_n),
      .start(start),
      .stop(stop),
      .loop(loop),
      .half_period(half_period),
      .tone_en(tone_en),
      .note_idx(note_idx),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if ({half_period, tone_en, note_idx, busy, done} !== 22'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got hp=%0d en=%b idx=%0d busy=%b done=%b, want all 0",
                  half_period, tone_en, note_idx, busy, done);
      end
      step();
      step();
      rst_n = 1'b1;
      repeat (3) step();
      n_run++;
      if ({half_period, tone_en, note_idx, busy, done} !== 22'd0) begin
         n_fail++;
         $display("FAIL idle_outputs: got hp=%0d en=%b idx=%0d busy=%b done=%b, want all 0",
                  half_period, tone_en, note_idx, busy, done);
      end
   endtask

   task automatic test_start();
      pulse_start();
      n_run++;
      if (half_period !== 16'd56818 || tone_en !== 1'b1 || note_idx !== 3'd0
          || busy !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL start_first: got hp=%0d en=%b idx=%0d busy=%b done=%b, want 56818 1 0 1 0",
                  half_period, tone_en, note_idx, busy, done);
      end
      pulse_stop();
      step();
   endtask

   task automatic test_full_run();
      int c, run, cur, exp_idx, done_at;
      loop = 1'b0;
      pulse_start();
      c = 0; run = 1; cur = 1; exp_idx = 0; done_at = -1;
      for (int i = 0; i < 12000; i++) begin
         step();
         c++;
         if (done === 1'b1) begin
            done_at = c;
            n_run++;
            if (run !== GT * TD) begin
               n_fail++;
               $display("FAIL last_gap_len: got %0d want %0d", run, GT * TD);
            end
            break;
         end
         if (tone_en !== cur[0]) begin
            if (cur == 1) begin
               n_run++;
               if (run !== ((exp_idx == 7) ? 500 * TD : 250 * TD)) begin
                  n_fail++;
                  $display("FAIL play_len note %0d: got %0d", exp_idx, run);
               end
               n_run++;
               if (half_period !== tbl[exp_idx] || note_idx !== 3'(exp_idx)) begin
                  n_fail++;
                  $display("FAIL gap_hold note %0d: got hp=%0d idx=%0d want hp=%0d",
                           exp_idx, half_period, note_idx, tbl[exp_idx]);
               end
            end else begin
               n_run++;
               if (run !== GT * TD) begin
                  n_fail++;
                  $display("FAIL gap_len note %0d: got %0d want %0d", exp_idx, run, GT * TD);
               end
               exp_idx++;
               n_run++;
               if (exp_idx > 7 || note_idx !== 3'(exp_idx) || half_period !== tbl[exp_idx]) begin
                  n_fail++;
                  $display("FAIL note_load %0d: got idx=%0d hp=%0d", exp_idx, note_idx, half_period);
               end
            end
            cur = int'(tone_en);
            run = 1;
         end else begin
            run++;
         end
      end
      n_run++;
      if (done_at !== 9064) begin
         n_fail++;
         $display("FAIL done_time: got %0d want 9064", done_at);
      end
      n_run++;
      if (busy !== 1'b0 || tone_en !== 1'b0) begin
         n_fail++;
         $display("FAIL done_busy: got busy=%b en=%b want 0 0", busy, tone_en);
      end
      step();
      n_run++;
      if (done !== 1'b0 || note_idx !== 3'd7 || half_period !== 16'd28409) begin
         n_fail++;
         $display("FAIL done_after: got done=%b idx=%0d hp=%0d want 0 7 28409",
                  done, note_idx, half_period);
      end
   endtask

   task automatic test_loop();
      int drops;
      drops = 0;
      loop = 1'b1;
      pulse_start();
      for (int i = 0; i < 12000 && !(note_idx == 3'd7 && tone_en == 1'b0); i++) begin
         step();
         if (busy !== 1'b1) drops++;
      end
      for (int i = 0; i < 20 && tone_en !== 1'b1; i++) begin
         step();
         if (busy !== 1'b1) drops++;
      end
      n_run++;
      if (note_idx !== 3'd0 || half_period !== 16'd56818 || tone_en !== 1'b1) begin
         n_fail++;
         $display("FAIL loop_wrap: got idx=%0d hp=%0d en=%b want 0 56818 1",
                  note_idx, half_period, tone_en);
      end
      n_run++;
      if (drops !== 0) begin
         n_fail++;
         $display("FAIL loop_busy: busy low %0d cycles, want 0", drops);
      end
      loop = 1'b0;
      for (int i = 0; i < 12000 && done !== 1'b1; i++) step();
      n_run++;
      if (done !== 1'b1 || note_idx !== 3'd7) begin
         n_fail++;
         $display("FAIL loop_end_done: got done=%b idx=%0d want 1 7", done, note_idx);
      end
      step();
   endtask

   task automatic test_stop();
      int bad;
      bad = 0;
      pulse_start();
      for (int i = 0; i < 5000 && note_idx !== 3'd3; i++) step();
      repeat (20) step();
      pulse_stop();
      n_run++;
      if (tone_en !== 1'b0 || busy !== 1'b0 || note_idx !== 3'd3
          || half_period !== 16'd42589 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_now: got en=%b busy=%b idx=%0d hp=%0d done=%b want 0 0 3 42589 0",
                  tone_en, busy, note_idx, half_period, done);
      end
      repeat (50) begin
         step();
         if (done !== 1'b0 || busy !== 1'b0 || note_idx !== 3'd3) bad++;
      end
      n_run++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL stop_hold: %0d bad cycles, want 0", bad);
      end
      pulse_start();
      n_run++;
      if (note_idx !== 3'd0 || half_period !== 16'd56818 || tone_en !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_replay: got idx=%0d hp=%0d en=%b want 0 56818 1",
                  note_idx, half_period, tone_en);
      end
      pulse_stop();
      step();
   endtask

   task automatic test_start_ignored();
      pulse_start();
      for (int i = 0; i < 4000 && note_idx !== 3'd2; i++) step();
      repeat (5) step();
      pulse_start();
      n_run++;
      if (note_idx !== 3'd2 || tone_en !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_busy: got idx=%0d en=%b busy=%b want 2 1 1",
                  note_idx, tone_en, busy);
      end
      pulse_stop();
      repeat (3) step();
      n_run++;
      if (busy !== 1'b0 || tone_en !== 1'b0) begin
         n_fail++;
         $display("FAIL start_not_queued: got busy=%b en=%b want 0 0", busy, tone_en);
      end
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      n_run++;
      if (busy !== 1'b0 || tone_en !== 1'b0) begin
         n_fail++;
         $display("FAIL start_stop_idle: got busy=%b en=%b want 0 0", busy, tone_en);
      end
      step();
   endtask

   task automatic test_reset_mid();
      pulse_start();
      for (int i = 0; i < 8000 && !(note_idx == 3'd5 && tone_en == 1'b0); i++) step();
      n_run++;
      if (note_idx !== 3'd5 || tone_en !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL reach_gap5: got idx=%0d en=%b busy=%b want 5 0 1",
                  note_idx, tone_en, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      n_run++;
      if ({half_period, tone_en, note_idx, busy, done} !== 22'd0) begin
         n_fail++;
         $display("FAIL async_reset: got hp=%0d en=%b idx=%0d busy=%b done=%b, want all 0",
                  half_period, tone_en, note_idx, busy, done);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      pulse_start();
      n_run++;
      if (note_idx !== 3'd0 || half_period !== 16'd56818 || tone_en !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_replay: got idx=%0d hp=%0d en=%b want 0 56818 1",
                  note_idx, half_period, tone_en);
      end
      repeat (250 * TD + GT * TD) step();
      n_run++;
      if (note_idx !== 3'd1 || half_period !== 16'd50607 || tone_en !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_note1: got idx=%0d hp=%0d en=%b want 1 50607 1",
                  note_idx, half_period, tone_en);
      end
      pulse_stop();
   endtask

   initial begin
      tbl[0] = 16'd56818; tbl[1] = 16'd50607;
      tbl[2] = 16'd45126; tbl[3] = 16'd42589;
      tbl[4] = 16'd37936; tbl[5] = 16'd33783;
      tbl[6] = 16'd30084; tbl[7] = 16'd28409;
      test_reset();
      test_start();
      test_full_run();
      test_loop();
      test_stop();
      test_start_ignored();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Note sequencer for the square-wave tone generator on the 50 MHz oscillator clock. On a start pulse it steps through a fixed 8-note table (A-major scale, A4 to A5). For each note it drives a half-period divider value and a tone enable for a fixed duration, then inserts a silent gap before the next note. It sits between the user controls and the tone generator that toggles the speaker pin. It only sequences that generator and produces no audio itself.

## Interface
- `TICK_DIV`, default 50000: oscillator cycles per duration tick (1 ms at 50 MHz).
- `GAP_TICKS`, default 20: silent ticks after every note, minimum 1.
- `NUM_NOTES`, default 8: table length, fixed at 8; note_idx is 3 bits.
- `osc_CLK` input, 1: single clock, rising edge.
- `rst_n` input, 1: reset, asynchronous, active-low.
- `start` input, 1: one-cycle request to begin playback; honoured only in IDLE.
- `stop` input, 1: abort playback, honoured in any state.
- `loop` input, 1: sampled at the end of the last gap; 1 restarts at note 0.
- `half_period` output, 16: divider for the tone generator, equal to 50000000/(2·f) rounded down.
- `tone_en` output, 1: 1 while a note sounds; the tone generator holds its pin when 0.
- `note_idx` output, 3: index of the current note.
- `busy` output, 1: 1 in PLAY or GAP.
- `done` output, 1: one-cycle pulse when the sequence completes without loop.

## Operation
- Note table, as index: half_period / duration ticks.
  - 0: 56818 / 250 (A4)
  - 1: 50607 / 250
  - 2: 45126 / 250
  - 3: 42589 / 250
  - 4: 37936 / 250
  - 5: 33783 / 250
  - 6: 30084 / 250
  - 7: 28409 / 500 (A5)
- Table is an internal constant ROM. Duration field is 10 bits.
- FSM states: IDLE, PLAY, GAP.
- IDLE + start, with stop=0:
  - Go to PLAY with note_idx=0.
  - half_period=table[0], tone_en=1, busy=1.
- PLAY: on the final tick of the note, go to GAP. tone_en=0; half_period holds its value.
- GAP: on the final tick, the next state depends on note_idx.
  - note_idx<7: note_idx+1, go to PLAY, load half_period from the table, tone_en=1.
  - note_idx==7 and loop=1: note_idx=0, go to PLAY.
  - note_idx==7 and loop=0: go to IDLE with busy=0 and done=1 for one cycle. note_idx stays at 7 and half_period holds.
- stop=1 in any state: go to IDLE next cycle. tone_en=0, busy=0, no done pulse, note_idx and half_period hold.
- stop has priority over start in the same cycle.
- start while busy is ignored. It neither restarts the sequence nor is queued.
- Prescaler: counts 0..TICK_DIV-1 and asserts the tick when the count is TICK_DIV-1.
  - It is cleared on every entry to PLAY or GAP, so the tick phase is aligned to the state.
- Duration counter: loaded on state entry (note duration, or GAP_TICKS).
  - It decrements on each tick.
  - The state exits on the tick where the counter equals 1.

## Timing
- All outputs are registered. Reset values: half_period=0, tone_en=0, note_idx=0, busy=0, done=0, state IDLE, prescaler and duration counter 0.
- Reset mid-note takes effect immediately and asynchronously; all outputs return to their reset values.
- start sampled on edge k: busy and tone_en are 1 after edge k, with half_period valid in the same cycle.
- PLAY lasts exactly duration·TICK_DIV cycles; GAP lasts exactly GAP_TICKS·TICK_DIV cycles.
- Full sequence without loop: start to done = (7·250 + 500 + 8·GAP_TICKS)·TICK_DIV cycles, with done in the cycle after busy falls to 0.
- Loop wrap: tone_en is 0 only during the gap; there is no extra IDLE cycle.
- stop sampled on edge k: tone_en=0 and busy=0 after edge k.
- start is accepted on the cycle after busy falls.

## Test plan
- Reset, then idle with TICK_DIV=4 and GAP_TICKS=2 -> all outputs 0; start pulse -> half_period=56818, tone_en=1, note_idx=0 on the next cycle.
- Full run, loop=0, TICK_DIV=4, GAP_TICKS=2 -> 8 notes at the table dividers; each PLAY lasts 1000 cycles (2000 for note 7), each GAP 8 cycles; done pulses once at cycle 9064.
- loop=1 held -> after note 7's gap, note_idx=0 and half_period=56818, busy never drops; then clear loop -> next pass ends with done.
- stop asserted in note 3 PLAY -> tone_en=0 and busy=0 next cycle, no done, note_idx stays 3; start then replays from note 0.
- start pulsed in note 2 -> ignored; start and stop together in IDLE -> stays in IDLE.
- rst_n driven low mid-GAP of note 5 -> all outputs 0 asynchronously; start after release -> normal playback from note 0.
